// File: rtl/recv_wrapper.sv
// recv_wrapper: UART 8N1 receiver feeding a show-ahead word FIFO.
// Received bytes are either packed four to a 32-bit word (LSB byte first)
// or stored one per entry, selected by byte_mode at the start of each word.
// Optional feature macro: RECV_FRAME_CHECK_EN adds stop-bit checking and the
// sticky frame_err output; without it the stop-bit value is ignored.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge
// START | timing to the start-bit centre to confirm it is still low
// DATA  | sampling 8 data bits at bit centres, LSB first
// STOP  | timing to the stop-bit centre, then the byte is complete
module recv_wrapper #(
  parameter int CLK_PER_HALF_BIT = 434,
  parameter int DEPTH            = 128
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        UART_RX,
  input  logic        byte_mode,
  input  logic        ready,
  output logic [31:0] data,
  output logic        valid,
  output logic        overflow
`ifdef RECV_FRAME_CHECK_EN
  ,
  output logic        frame_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(2 * CLK_PER_HALF_BIT) + 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(2 * CLK_PER_HALF_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [1:0]    byte_idx;
  logic [23:0]   word_buf;
  logic          push_req;
  logic [31:0]   push_data;

  logic rx_meta, rx_sync, rx_prev;

  logic [AW:0]  wr_ptr, rd_ptr;
  logic [31:0]  mem [DEPTH];
  logic         full, empty, do_pop, do_push;
  logic         byte_sel;

  // Mode is only honoured at a word boundary; a partial word always finishes
  // in word mode.
  assign byte_sel = (byte_idx == 2'd0) && byte_mode;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection;
  // all reset high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver FSM with byte assembly; emits a one-cycle push request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      byte_idx  <= '0;
      word_buf  <= '0;
      push_req  <= 1'b0;
      push_data <= '0;
`ifdef RECV_FRAME_CHECK_EN
      frame_err <= 1'b0;
`endif
    end else begin
      push_req <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_prev && !rx_sync) begin
            state <= START;
            cnt   <= HALF_LOAD;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (!rx_sync) begin
              state   <= DATA;
              cnt     <= BIT_LOAD;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shift <= {rx_sync, shift[7:1]};
            cnt   <= BIT_LOAD;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (cnt == '0) begin
            state <= IDLE;
`ifdef RECV_FRAME_CHECK_EN
            if (!rx_sync) begin
              frame_err <= 1'b1;
              byte_idx  <= '0;
              word_buf  <= '0;
            end else
`endif
            begin
              if (byte_sel) begin
                push_req  <= 1'b1;
                push_data <= {24'b0, shift};
              end else begin
                case (byte_idx)
                  2'd0: word_buf[7:0]   <= shift;
                  2'd1: word_buf[15:8]  <= shift;
                  2'd2: word_buf[23:16] <= shift;
                  default: begin
                    push_req  <= 1'b1;
                    push_data <= {shift, word_buf};
                    word_buf  <= '0;
                  end
                endcase
                byte_idx <= byte_idx + 1'b1;
              end
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = ready && !empty;
  assign do_push = push_req && (!full || do_pop);

  // FIFO pointers and sticky overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push_req && full && !do_pop) overflow <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset because data is gated by valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign valid = !empty;
  assign data  = valid ? mem[rd_ptr[AW-1:0]] : 32'h0;

endmodule

// File: doc/recv_wrapper.md
RECV_WRAPPER -- requirements
Module: recv_wrapper

Interface
REQ-001 Parameter CLK_PER_HALF_BIT, default 434, clk cycles per half UART bit period.
REQ-002 Parameter DEPTH, default 128, word FIFO entries, power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 UART_RX  input  1  serial line, idle high, 8N1, LSB first.
REQ-006 byte_mode  input  1  1: each received byte SHALL form its own FIFO entry; 0: four bytes SHALL form one word.
REQ-007 ready  input  1  consumer accepts the head entry when ready and valid are both high.
REQ-008 data  output  32  head-of-FIFO entry, valid only while valid=1.
REQ-009 valid  output  1  FIFO non-empty.
REQ-010 overflow  output  1  sticky; an entry was dropped because the FIFO was full.
REQ-011 frame_err  output  1  sticky bad-stop-bit flag; present only with RECV_FRAME_CHECK_EN.

Function
REQ-012 UART_RX SHALL pass through a 2-flop synchronizer before any use.
REQ-013 The receiver FSM SHALL have states IDLE, START, DATA and STOP.
REQ-014 IDLE->START on a synchronized high-to-low transition; the bit counter SHALL load CLK_PER_HALF_BIT-1.
REQ-015 START: at count 0, sample the line; low->DATA with a 2*CLK_PER_HALF_BIT-1 reload; high->IDLE (glitch, nothing pushed).
REQ-016 DATA: sample once per 2*CLK_PER_HALF_BIT at bit centre, 8 bits, LSB first; after bit 7->STOP.
REQ-017 STOP: sample at stop-bit centre, then return to IDLE in the same cycle; the byte SHALL be complete at this sample.
REQ-018 Word mode: byte k (k=0..3) SHALL occupy bits [8k+7:8k]; the word SHALL be pushed when byte 3 completes; the byte index then returns to 0.
REQ-019 Byte mode: the entry SHALL be {24'b0, byte}, pushed on each byte completion.
REQ-020 byte_mode SHALL be sampled only when the byte index is 0; a partial word SHALL complete in word mode regardless of later byte_mode changes.
REQ-021 A push SHALL occur on the cycle after the completing stop-bit sample; valid SHALL rise one cycle after the push.
REQ-022 The FIFO SHALL be show-ahead: data reflects the head combinationally from the read pointer; a pop advances it.
REQ-023 Pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full = MSBs differ and the rest are equal; empty = equal.
REQ-024 Push when full without a same-cycle pop SHALL drop the entry and set overflow; FIFO contents are unchanged.
REQ-025 Simultaneous push and pop when full SHALL accept both; occupancy stays DEPTH.
REQ-026 Simultaneous push and pop when empty SHALL perform only the push; the pop is ignored because valid=0.
REQ-027 ready while valid=0 SHALL have no effect.
REQ-028 overflow and frame_err SHALL clear only on reset.

Reset
REQ-029 rstn low SHALL immediately force FSM=IDLE, the counters, byte index and pointers to 0, valid=0, data=0, overflow=0 and frame_err=0.
REQ-030 Synchronizer flops SHALL reset to 1 (line idle) so that no false start follows reset release.
REQ-031 Reset mid-frame SHALL discard the partial byte and word; reception resumes at the next start edge after release.

Configuration
REQ-032 Macro RECV_FRAME_CHECK_EN defined: a low stop-bit sample SHALL discard the byte (no byte-index advance, no push), set frame_err, and clear the partial word.
REQ-033 RECV_FRAME_CHECK_EN undefined: the stop-bit value SHALL be ignored, every byte accepted, and the frame_err port absent.

Verification
REQ-034 Word mode, serial bytes 0x78,0x56,0x34,0x12 -> one entry data=0x12345678, valid high one cycle after the push, single-cycle ready pops it, valid=0.
REQ-035 Byte mode, bytes 0xA5,0x3C -> entries 0x000000A5 then 0x0000003C, in order.
REQ-036 Low glitch of CLK_PER_HALF_BIT/2 cycles on idle line -> FSM back to IDLE, no push.
REQ-037 ready=0, DEPTH+1 bytes in byte mode -> DEPTH entries retained 0..DEPTH-1, overflow=1, last byte dropped; drain returns exactly DEPTH entries.
REQ-038 rstn pulsed after the 2nd byte of a word, then 4 new bytes 0x01..0x04 -> single entry 0x04030201.
REQ-039 RECV_FRAME_CHECK_EN defined, byte 0x55 with stop bit 0 -> frame_err=1, no entry, next good word received intact.
